uart_avs_responder: RTL and testbench

Avalon-MM slave that implements the RS-232 UART register map polled by the RSA wrapper master: RX data at byte address 0, TX data at 4, status at 8. It converts the 8N1 serial line into single-byte RX holding and TX holding registers. It is the responder end of the wrapper's status-poll / read / write protocol. It sits between the wrapper's `avm_*` port and the board serial pins, and is also used as the bus model in the wrapper's testbench.

---
 rtl/uart_avs_if.sv | 19 +
 rtl/uart_avs_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_avs_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_avs_if.sv
// Avalon-MM slave bus bundle between the RSA wrapper master and the UART responder.
interface uart_avs_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/uart_avs_responder.sv
// UART register block: RX data @0, TX data @4, STATUS @8, 8N1 serial line.
// Every bus access takes one request cycle plus one acknowledge cycle.
module uart_avs_responder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       avm_clk,
    input  logic       avm_rst_n,
    uart_avs_if.slave  avs,
    input  logic       uart_rxd,
    output logic       uart_txd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic {BUS_IDLE, BUS_ACK}  bus_state_t;
    typedef enum logic {RX_HUNT, RX_FRAME}  rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND}   tx_state_t;

    bus_state_t bus_state, bus_next;
    rx_state_t  rx_state, rx_next;
    tx_state_t  tx_state, tx_next;

    // latched access
    logic [4:0]  acc_addr;
    logic        acc_rd, acc_wr;
    logic [7:0]  acc_data;
    logic [31:0] readdata;
    logic [31:0] rd_value;

    // register state
    logic       rrdy, roe, fe, tx_full;
    logic [7:0] rx_hold, tx_hold;
    logic [7:0] status;

    // rx path
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_sample, rx_done, rx_ferr;

    // tx path
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [9:0]    tx_frame;
    logic          tx_end, tx_load;

    logic ack, rx_clr, st_clr, tx_wr;
    logic unused_wdata;

    assign unused_wdata = ^avs.avs_writedata[31:8];

    assign status = {rrdy, ~tx_full, 2'b00, roe, fe, 2'b00};
    assign ack    = (bus_state == BUS_ACK);
    assign rx_clr = ack && acc_rd && (acc_addr == 5'd0);
    assign st_clr = ack && acc_wr && (acc_addr == 5'd8);
    assign tx_wr  = ack && acc_wr && (acc_addr == 5'd4) && !tx_full;

    assign avs.avs_waitrequest = !ack;
    assign avs.avs_readdata    = readdata;

    // Read mux sampled in the request cycle so data is valid during acknowledge.
    always_comb begin
        rd_value = 32'd0;
        case (avs.avs_address)
            5'd0:    rd_value = {24'd0, rx_hold};
            5'd8:    rd_value = {24'd0, status};
            default: rd_value = 32'd0;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) bus_state <= BUS_IDLE;
        else            bus_state <= bus_next;
    end

    // Bus FSM: a request in IDLE always yields exactly one acknowledge cycle.
    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            BUS_IDLE: if (avs.avs_read || avs.avs_write) bus_next = BUS_ACK;
            BUS_ACK:  bus_next = BUS_IDLE;
            default:  bus_next = BUS_IDLE;
        endcase
    end

    // Capture the access; a simultaneous read and write is taken as a read.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            acc_addr <= 5'd0;
            acc_rd   <= 1'b0;
            acc_wr   <= 1'b0;
            acc_data <= 8'd0;
            readdata <= 32'd0;
        end else if (bus_state == BUS_IDLE && (avs.avs_read || avs.avs_write)) begin
            acc_addr <= avs.avs_address;
            acc_rd   <= avs.avs_read;
            acc_wr   <= avs.avs_write && !avs.avs_read;
            acc_data <= avs.avs_writedata[7:0];
            readdata <= avs.avs_read ? rd_value : 32'd0;
        end
    end

    // Two-flop synchronizer plus one delay for falling-edge detection.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // Start bit is sampled half a bit in; later bits a full bit apart.
    assign rx_sample = (rx_bit == 4'd0) ? (rx_cnt == BAUD_HALF) : (rx_cnt == BAUD_LAST);

    // RX FSM state register.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) rx_state <= RX_HUNT;
        else            rx_state <= rx_next;
    end

    // RX FSM: hunt for a falling edge, then walk start, 8 data and stop bits.
    always_comb begin
        rx_next = rx_state;
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        case (rx_state)
            RX_HUNT: if (rx_prev && !rx_s2) rx_next = RX_FRAME;
            RX_FRAME: begin
                if (rx_sample) begin
                    if (rx_bit == 4'd0 && rx_s2) begin
                        rx_next = RX_HUNT;
                    end else if (rx_bit == 4'd9) begin
                        rx_next = RX_HUNT;
                        rx_done = rx_s2;
                        rx_ferr = !rx_s2;
                    end
                end
            end
            default: rx_next = RX_HUNT;
        endcase
    end

    // RX baud/bit counters and LSB-first shift register.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rx_cnt   <= '0;
            rx_bit   <= 4'd0;
            rx_shift <= 8'd0;
        end else if (rx_state == RX_HUNT) begin
            rx_cnt <= '0;
            rx_bit <= 4'd0;
        end else if (rx_sample) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 4'd1;
            if (rx_bit != 4'd0 && rx_bit != 4'd9) rx_shift <= {rx_s2, rx_shift[7:1]};
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    // Holding registers and flags; line events take priority over bus clears.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            rrdy    <= 1'b0;
            roe     <= 1'b0;
            fe      <= 1'b0;
            rx_hold <= 8'd0;
            tx_full <= 1'b0;
            tx_hold <= 8'd0;
        end else begin
            if (rx_done && (!rrdy || rx_clr)) begin
                rx_hold <= rx_shift;
                rrdy    <= 1'b1;
            end else if (rx_clr) begin
                rrdy <= 1'b0;
            end
            if (rx_done && rrdy && !rx_clr) roe <= 1'b1;
            else if (st_clr)                roe <= 1'b0;
            if (rx_ferr)     fe <= 1'b1;
            else if (st_clr) fe <= 1'b0;
            if (tx_wr) begin
                tx_hold <= acc_data;
                tx_full <= 1'b1;
            end else if (tx_load) begin
                tx_full <= 1'b0;
            end
        end
    end

    assign tx_end  = (tx_state == TX_SEND) && (tx_cnt == BAUD_LAST) && (tx_bit == 4'd9);
    assign tx_load = tx_full && ((tx_state == TX_IDLE) || tx_end);

    // TX FSM state register.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) tx_state <= TX_IDLE;
        else            tx_state <= tx_next;
    end

    // TX FSM: a waiting byte follows the stop bit with no idle gap.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_full) tx_next = TX_SEND;
            TX_SEND: if (tx_end)  tx_next = tx_full ? TX_SEND : TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX frame shifter; bit 0 drives the line and idles at 1.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= 4'd0;
            tx_frame <= '1;
        end else if (tx_load) begin
            tx_cnt   <= '0;
            tx_bit   <= 4'd0;
            tx_frame <= {1'b1, tx_hold, 1'b0};
        end else if (tx_state == TX_SEND) begin
            if (tx_cnt == BAUD_LAST) begin
                tx_cnt   <= '0;
                tx_bit   <= tx_bit + 4'd1;
                tx_frame <= {1'b1, tx_frame[9:1]};
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign uart_txd = tx_frame[0];
endmodule

// File: tb/tb_uart_avs_responder.sv
// Directed bench for uart_avs_responder at 4 clocks per serial bit.
module tb_uart_avs_responder;
    localparam int CPB = 4;

    logic clk;
    logic rst_n;
    logic rxd;
    logic txd;
    int   tests;
    int   failed;

    uart_avs_if bus ();

    uart_avs_responder #(.CLKS_PER_BIT(CPB)) dut (
        .avm_clk   (clk),
        .avm_rst_n (rst_n),
        .avs       (bus),
        .uart_rxd  (rxd),
        .uart_txd  (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input logic [4:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, output logic [31:0] rdata);
        bit done;
        done = 0;
        rdata = 32'hDEAD_BEEF;
        bus.avs_address   = a;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_writedata = wd;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.avs_waitrequest === 1'b0) begin
                done  = 1;
                rdata = bus.avs_readdata;
            end
        end
        check("ack_seen", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] want);
        logic [31:0] d;
        access(a, 1'b1, 1'b0, 32'd0, d);
        check(tag, d, want);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] wd);
        logic [31:0] d;
        access(a, 1'b0, 1'b1, wd, d);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            cycles(CPB);
        end
        rxd = stop;
        cycles(CPB);
        rxd = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  frame;
        int          bad;
        tests = 0;
        failed = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        rxd = 1'b1;
        bus.avs_address = 5'd0;
        bus.avs_read = 1'b0;
        bus.avs_write = 1'b0;
        bus.avs_writedata = 32'd0;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_wait", {31'd0, bus.avs_waitrequest}, 32'd1);
        check("rst_rdata", bus.avs_readdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycles(1);
        @(negedge clk);
        check("post_rst_txd", {31'd0, txd}, 32'd1);
        check("post_rst_wait", {31'd0, bus.avs_waitrequest}, 32'd1);
        cycles(1);
        rd_check("rst_status", 5'd8, 32'h40);
        @(negedge clk);
        check("wait_one_cycle", {31'd0, bus.avs_waitrequest}, 32'd1);
        cycles(1);
        rd_check("other_addr", 5'd12, 32'd0);

        // receive 0xA5
        send_serial(8'hA5, 1'b1);
        cycles(4);
        rd_check("rx_status_full", 5'd8, 32'hC0);
        rd_check("rx_data", 5'd0, 32'hA5);
        rd_check("rx_status_empty", 5'd8, 32'h40);

        // transmit 0x3C and watch every bit cell
        wr(5'd4, 32'h3C);
        @(negedge clk);
        check("tx_pre_start", {31'd0, txd}, 32'd1);
        frame = {1'b1, 8'h3C, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                check($sformatf("tx_bit%0d_c%0d", b, c), {31'd0, txd}, {31'd0, frame[b]});
            end
        end
        @(negedge clk);
        check("tx_idle_after", {31'd0, txd}, 32'd1);
        cycles(1);
        rd_check("tx_status_done", 5'd8, 32'h40);

        // TRDY drops for one cycle, and stays low while a second byte waits
        wr(5'd4, 32'h81);
        rd_check("trdy_low", 5'd8, 32'h00);
        rd_check("trdy_back", 5'd8, 32'h40);
        wr(5'd4, 32'h55);
        rd_check("trdy_held", 5'd8, 32'h00);
        cycles(100);
        rd_check("tx_pair_done", 5'd8, 32'h40);
        check("tx_pair_idle", {31'd0, txd}, 32'd1);

        // read and write together act as a read only
        access(5'd4, 1'b1, 1'b1, 32'h99, d);
        check("rw_rdata", d, 32'd0);
        @(negedge clk);
        check("rw_no_tx_a", {31'd0, txd}, 32'd1);
        @(negedge clk);
        check("rw_no_tx_b", {31'd0, txd}, 32'd1);
        cycles(1);
        rd_check("rw_status", 5'd8, 32'h40);

        // overrun
        send_serial(8'h11, 1'b1);
        send_serial(8'h22, 1'b1);
        cycles(4);
        rd_check("ovr_status", 5'd8, 32'hC8);
        rd_check("ovr_data", 5'd0, 32'h11);
        rd_check("ovr_status_read", 5'd8, 32'h48);
        wr(5'd8, 32'hFFFF_FFFF);
        rd_check("ovr_cleared", 5'd8, 32'h40);

        // framing error
        send_serial(8'h5A, 1'b0);
        cycles(4);
        rd_check("fe_status", 5'd8, 32'h44);
        wr(5'd8, 32'h0);
        rd_check("fe_cleared", 5'd8, 32'h40);

        // reset during data bit 3 of a TX frame
        wr(5'd4, 32'h00);
        repeat (18) @(negedge clk);
        check("mid_frame_low", {31'd0, txd}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_wait", {31'd0, bus.avs_waitrequest}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) bad++;
        end
        check("no_residual_bits", bad, 32'd0);
        cycles(1);
        rd_check("mid_rst_status", 5'd8, 32'h40);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
